// File: rtl/tpu_seq.sv
// Load/clear/compute/done sequencer for a DIM x DIM systolic matrix-multiply pass.
// It fills memA/memB row by row, clears the MAC grid, then streams operands for 3*DIM-2 cycles.
module tpu_seq #(
    parameter int DIM = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_en,
    output logic                   mem_wren,
    output logic [$clog2(DIM)-1:0] mem_row,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   busy,
    output logic                   done
);

    localparam int ROW_W  = $clog2(DIM);
    localparam int STEP_W = $clog2(3 * DIM);

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DIM - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(3 * DIM - 3);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [STEP_W-1:0]   step_q, step_d;

    // in_ready depends only on state, so a stalled host cannot form a loop through it.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        step_d   = step_q;
        in_ready = 1'b0;
        mem_en   = 1'b0;
        mem_wren = 1'b0;
        mem_row  = '0;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                mem_row  = row_q;
                if (in_valid) begin
                    mem_en   = 1'b1;
                    mem_wren = 1'b1;
                    row_d    = row_q + ROW_ONE;
                    if (row_q == ROW_LAST) begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                mac_clr = 1'b1;
                state_d = S_COMPUTE;
                step_d  = '0;
            end
            S_COMPUTE: begin
                mem_en = 1'b1;
                mac_en = 1'b1;
                if (step_q == STEP_LAST) begin
                    state_d = S_DONE;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: tb/tb_tpu_seq.sv
// Self-checking bench for tpu_seq: timeline table, directed corner sequences,
// randomized traffic against a transfer-counting reference model, and a DIM=4 pass.
module tb_tpu_seq;

    localparam int DIM  = 8;
    localparam int DIM4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n, start, in_valid;
    logic                   in_ready, mem_en, mem_wren, mac_clr, mac_en, busy, done;
    logic [$clog2(DIM)-1:0] mem_row;

    logic                    rst4, start4, valid4;
    logic                    ready4, en4, wren4, clr4, mac4, busy4, done4;
    logic [$clog2(DIM4)-1:0] row4;

    tpu_seq #(.DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .mem_en(mem_en), .mem_wren(mem_wren), .mem_row(mem_row),
        .mac_clr(mac_clr), .mac_en(mac_en), .busy(busy), .done(done)
    );

    tpu_seq #(.DIM(DIM4)) dut4 (
        .clk(clk), .rst_n(rst4), .start(start4), .in_valid(valid4),
        .in_ready(ready4), .mem_en(en4), .mem_wren(wren4), .mem_row(row4),
        .mac_clr(clr4), .mac_en(mac4), .busy(busy4), .done(done4)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: counts accepted rows, then cycles elapsed since the last row.
    bit m_busy   = 1'b0;
    int m_loaded = 0;
    int m_after  = 0;

    logic s_busy, s_ready, s_en, s_wren, s_clr, s_mac, s_done;
    int   s_row;

    typedef struct {
        int cyc;
        bit busy;
        bit ready;
        bit en;
        int row;
        bit clr;
        bit mac;
        bit done;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // One cycle: drive inputs, compare every output against the model, then advance the model.
    task automatic applyStimulus(input bit s, input bit v, input bit r);
        bit loading;
        bit in_compute;
        @(negedge clk);
        start = s; in_valid = v; rst_n = r;
        #1;
        s_busy = busy; s_ready = in_ready; s_en = mem_en; s_wren = mem_wren;
        s_row = int'(mem_row); s_clr = mac_clr; s_mac = mac_en; s_done = done;

        loading    = m_busy && (m_loaded < DIM);
        in_compute = m_busy && !loading && (m_after >= 2) && (m_after <= 3 * DIM - 1);
        checkOutput("busy",     s_busy,  m_busy);
        checkOutput("in_ready", s_ready, loading);
        checkOutput("mem_en",   s_en,    (loading && v) || in_compute);
        checkOutput("mem_wren", s_wren,  loading && v);
        checkOutput("mem_row",  s_row,   loading ? m_loaded : 0);
        checkOutput("mac_clr",  s_clr,   m_busy && !loading && (m_after == 1));
        checkOutput("mac_en",   s_mac,   in_compute);
        checkOutput("done",     s_done,  m_busy && !loading && (m_after == 3 * DIM));

        if (r) begin
            m_busy = 1'b0; m_loaded = 0; m_after = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1; m_loaded = 0; m_after = 0;
            end
        end else if (loading) begin
            if (v) begin
                m_loaded++;
                if (m_loaded == DIM) m_after = 1;
            end
        end else if (m_after == 3 * DIM) begin
            m_busy = 1'b0;
        end else begin
            m_after++;
        end
        cyc++;
    endtask

    vec_t tbl[$];
    int   done_at, done_cnt, busy_after;
    int   loads4, mac4_cnt, done4_at;

    initial begin
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        rst4  = 1'b1; start4 = 1'b0; valid4 = 1'b0;
        repeat (2) @(posedge clk);

        tbl.push_back('{0,  0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1,  1, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{4,  1, 1, 1, 3, 0, 0, 0});
        tbl.push_back('{8,  1, 1, 1, 7, 0, 0, 0});
        tbl.push_back('{9,  1, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{10, 1, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{31, 1, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{32, 1, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{33, 0, 0, 0, 0, 0, 0, 0});

        // Continuous-input pass compared against the fixed timeline.
        $display("[TB] continuous pass DIM=%0d", DIM);
        for (int c = 0; c < 34; c++) begin
            applyStimulus(c == 0, 1'b1, 1'b0);
            foreach (tbl[k]) begin
                if (tbl[k].cyc == c) begin
                    checkOutput("tbl_busy",  s_busy,  tbl[k].busy);
                    checkOutput("tbl_ready", s_ready, tbl[k].ready);
                    checkOutput("tbl_en",    s_en,    tbl[k].en);
                    checkOutput("tbl_row",   s_row,   tbl[k].row);
                    checkOutput("tbl_clr",   s_clr,   tbl[k].clr);
                    checkOutput("tbl_mac",   s_mac,   tbl[k].mac);
                    checkOutput("tbl_done",  s_done,  tbl[k].done);
                end
            end
        end

        // Three-cycle stall after row 3 pushes done out by three cycles.
        $display("[TB] stall after row 3");
        done_at = -1; done_cnt = 0;
        for (int c = 0; c < 45; c++) begin
            applyStimulus(c == 0, !(c >= 5 && c <= 7), 1'b0);
            if (c >= 5 && c <= 7) begin
                checkOutput("stall_mem_en",  s_en,  0);
                checkOutput("stall_mem_row", s_row, 4);
            end
            if (s_done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        checkOutput("stall_done_cycle", done_at, 35);
        checkOutput("stall_done_count", done_cnt, 1);

        // Start pulses during COMPUTE are ignored.
        $display("[TB] start during compute");
        done_at = -1; done_cnt = 0; busy_after = -1;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(c == 0 || c == 15 || c == 20, 1'b1, 1'b0);
            if (s_done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == 33) busy_after = s_busy;
        end
        checkOutput("ign_done_cycle", done_at, 32);
        checkOutput("ign_done_count", done_cnt, 1);
        checkOutput("ign_busy_after", busy_after, 0);

        // Reset mid-COMPUTE aborts the pass; a fresh pass then completes normally.
        $display("[TB] reset during compute");
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(c == 0, 1'b1, c == 15);
            if (c == 16) begin
                checkOutput("abort_busy",   s_busy, 0);
                checkOutput("abort_mem_en", s_en,   0);
                checkOutput("abort_mac_en", s_mac,  0);
            end
            if (s_done) done_cnt++;
        end
        checkOutput("abort_no_done", done_cnt, 0);
        done_at = -1;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(c == 0, 1'b1, 1'b0);
            if (s_done && done_at < 0) done_at = c;
        end
        checkOutput("restart_done_cycle", done_at, 32);

        // Start coincident with reset leaves the sequencer idle.
        $display("[TB] start with reset");
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("rststart_busy",  s_busy,  0);
        checkOutput("rststart_ready", s_ready, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 199) == 0);
        end

        // DIM=4 instance, continuous input.
        $display("[TB] continuous pass DIM=%0d", DIM4);
        @(negedge clk);
        rst4 = 1'b0;
        loads4 = 0; mac4_cnt = 0; done4_at = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            start4 = (c == 0); valid4 = 1'b1;
            #1;
            if (en4 && wren4) begin
                checkOutput("dim4_row", int'(row4), loads4);
                loads4++;
            end
            if (mac4) mac4_cnt++;
            if (done4 && done4_at < 0) done4_at = c;
        end
        checkOutput("dim4_loads",  loads4,   4);
        checkOutput("dim4_mac_en", mac4_cnt, 10);
        checkOutput("dim4_done",   done4_at, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tpu_seq.md
TPU_SEQ -- requirements
Module: tpu_seq

Interface
REQ-001 Parameter DIM, default 8: systolic array dimension (rows of memA, MAC grid size); SHALL be a power of two, 2..16.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  synchronous active-high reset, sampled on rising clk (1 = reset).
REQ-004 start  input  1  pulse from host requesting one matrix-multiply pass.
REQ-005 in_valid  input  1  host has an A/B row pair on the data bus this cycle.
REQ-006 in_ready  output  1  sequencer accepts the row this cycle; transfer = in_valid & in_ready.
REQ-007 mem_en  output  1  enable to memA/memB (shift and write advance).
REQ-008 mem_wren  output  1  write enable to memA/memB (1 = load row, 0 = stream out).
REQ-009 mem_row  output  $clog2(DIM)  row index for the current load write.
REQ-010 mac_clr  output  1  one-cycle accumulator clear to the MAC array.
REQ-011 mac_en  output  1  MAC array advance enable.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at end of pass; results valid in MAC array.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, CLEAR, COMPUTE, DONE; encoding free.
REQ-015 IDLE: in_ready=0, mem_en=0, mem_wren=0, mac_en=0; start=1 -> LOAD next cycle, row counter := 0.
REQ-016 LOAD: in_ready=1; on each transfer mem_en=1, mem_wren=1, mem_row=row counter, counter += 1; no transfer -> mem_en=0, counter held (stall of any length allowed).
REQ-017 LOAD exits to CLEAR on the cycle after the transfer with mem_row=DIM-1; exactly DIM transfers per pass.
REQ-018 CLEAR: single cycle, mac_clr=1, in_ready=0, mem_en=0, mac_en=0; -> COMPUTE, step counter := 0.
REQ-019 COMPUTE: mem_en=1, mem_wren=0, mac_en=1 for exactly 3*DIM-2 consecutive cycles (skew fill + DIM products + drain); then -> DONE.
REQ-020 Step counter width SHALL be $clog2(3*DIM) bits; no wrap within a pass.
REQ-021 DONE: single cycle, done=1, all enables 0; -> IDLE.
REQ-022 start while busy=1 SHALL be ignored (not queued).
REQ-023 start and reset in same cycle: reset wins, FSM remains IDLE.
REQ-024 in_valid while in_ready=0 SHALL have no effect; mem_row SHALL read 0 outside LOAD.
REQ-025 All outputs SHALL be registered or decoded from state/counters only; no combinational path from in_valid to in_ready.
REQ-026 Pass latency with in_valid held high: start at cycle 0 -> done at cycle 1+DIM+1+(3*DIM-2) = 4*DIM (32 for DIM=8).

Reset
REQ-027 Reset SHALL force IDLE, row and step counters 0, every output 0, on the next rising edge.
REQ-028 Reset asserted mid-LOAD or mid-COMPUTE SHALL abort the pass: no done pulse, outputs 0 the following cycle, next start begins a fresh pass at row 0.

Verification
REQ-029 DIM=8, start, in_valid=1 continuously -> mem_row 0..7 on cycles 1..8, mac_clr at 9, mac_en cycles 10..31, done at 32, busy 1..32.
REQ-030 in_valid deasserted for 3 cycles after row 3 -> mem_en=0 and mem_row held at 4 during stall, done delayed by exactly 3 cycles (cycle 35).
REQ-031 start pulsed during COMPUTE -> no effect; single done pulse; busy drops cycle after done.
REQ-032 Reset asserted at cycle 15 (COMPUTE) -> all outputs 0 at 16, no done; new start completes normally in 32 cycles.
REQ-033 start coincident with reset -> stays IDLE, busy=0, in_ready=0.
REQ-034 DIM=4, continuous input -> 4 loads, mac_en high 10 cycles, done at cycle 16.
